// File: rtl/fsm_arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter: state encoding and defaults.
package fsm_arb_pkg;

   localparam int unsigned STATE_W      = 2;
   localparam int unsigned HOLD_MAX_DEF = 8;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      GA   = 2'd1,
      GB   = 2'd2,
      GAP  = 2'd3
   } state_t;

endpackage

// File: rtl/arb_hold_cnt.sv
// Grant-length counter: cleared on grant entry, counts granted cycles, flags the last allowed one.
module arb_hold_cnt #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] max,
   output logic             hit
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign hit = en && (r_cnt == max);

endmodule

// File: rtl/fsm_arb2_rr.sv
// Two-requester round-robin arbiter, Moore machine with outputs registered from the next state.
// Optional forced release after HOLD_MAX granted cycles when ARB2_TIMEOUT_EN is defined.
module fsm_arb2_rr
   import fsm_arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = HOLD_MAX_DEF,
   parameter int unsigned CNT_W    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic reqA,
   input  logic reqB,
   input  logic doneA,
   input  logic doneB,
   output logic gntA,
   output logic gntB,
   output logic busy,
   output logic tout
);

   if (HOLD_MAX < 2 || HOLD_MAX > (1 << CNT_W)) begin : g_bad_cfg
      $error("HOLD_MAX must lie in 2..2**CNT_W");
   end

   state_t r_state;
   state_t w_next;
   logic   r_last;
   logic   r_gntA;
   logic   r_gntB;
   logic   r_busy;

`ifdef ARB2_TIMEOUT_EN
   logic w_hit;
   logic w_clr;
   logic w_en;
   logic w_tout_nxt;
   logic r_tout;

   assign w_clr = (r_state == IDLE) && ((w_next == GA) || (w_next == GB));
   assign w_en  = (r_state == GA) || (r_state == GB);

   arb_hold_cnt #(
      .CNT_W (CNT_W)
   ) u_hold_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (w_clr),
      .en    (w_en),
      .max   (CNT_W'(HOLD_MAX - 1)),
      .hit   (w_hit)
   );
`endif

   always_comb begin
      w_next = IDLE;
`ifdef ARB2_TIMEOUT_EN
      w_tout_nxt = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            // last=1 means B went last, so A wins a tie
            if (reqA && reqB) begin
               w_next = r_last ? GA : GB;
            end else if (reqA) begin
               w_next = GA;
            end else if (reqB) begin
               w_next = GB;
            end
         end
         GA: begin
            if (doneA || !reqA) begin
               w_next = GAP;
`ifdef ARB2_TIMEOUT_EN
            end else if (w_hit) begin
               w_next     = GAP;
               w_tout_nxt = 1'b1;
`endif
            end else begin
               w_next = GA;
            end
         end
         GB: begin
            if (doneB || !reqB) begin
               w_next = GAP;
`ifdef ARB2_TIMEOUT_EN
            end else if (w_hit) begin
               w_next     = GAP;
               w_tout_nxt = 1'b1;
`endif
            end else begin
               w_next = GB;
            end
         end
         GAP:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last <= 1'b1;
      end else if (r_state == IDLE && w_next == GA) begin
         r_last <= 1'b0;
      end else if (r_state == IDLE && w_next == GB) begin
         r_last <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_gntA <= 1'b0;
         r_gntB <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_gntA <= (w_next == GA);
         r_gntB <= (w_next == GB);
         r_busy <= (w_next != IDLE);
      end
   end

`ifdef ARB2_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tout <= 1'b0;
      end else begin
         r_tout <= w_tout_nxt;
      end
   end

   assign tout = r_tout;
`else
   assign tout = 1'b0;
`endif

   assign gntA = r_gntA;
   assign gntB = r_gntB;
   assign busy = r_busy;

endmodule

// File: tb/tb_fsm_arb2_rr.sv
// Self-checking bench for fsm_arb2_rr: directed scenarios plus randomized traffic vs an owner model.
module tb_fsm_arb2_rr;

   localparam int unsigned HOLD = 4;

   logic clk = 1'b0;
   logic reset, reqA, reqB, doneA, doneB;
   logic gntA, gntB, busy, tout;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the resource, whether we are in turnaround, who won last.
   int m_owner;   // 0 none, 1 A, 2 B
   bit m_gap;
   bit m_lastB;
   int m_held;    // granted cycles so far, including the current one
   bit m_tout;

   always #5 clk = ~clk;

   fsm_arb2_rr #(
      .HOLD_MAX (HOLD),
      .CNT_W    (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .reqA  (reqA),
      .reqB  (reqB),
      .doneA (doneA),
      .doneB (doneB),
      .gntA  (gntA),
      .gntB  (gntB),
      .busy  (busy),
      .tout  (tout)
   );

   task automatic model_edge();
      bit d, r;
      if (reset) begin
         m_owner = 0; m_gap = 0; m_lastB = 1; m_held = 0; m_tout = 0;
      end else begin
         m_tout = 0;
         if (m_gap) begin
            m_gap = 0;
         end else if (m_owner == 0) begin
            if (reqA && reqB) m_owner = m_lastB ? 1 : 2;
            else if (reqA) m_owner = 1;
            else if (reqB) m_owner = 2;
            if (m_owner != 0) begin
               m_lastB = (m_owner == 2);
               m_held  = 1;
            end
         end else begin
            d = (m_owner == 1) ? doneA : doneB;
            r = (m_owner == 1) ? reqA : reqB;
            if (d || !r) begin
               m_owner = 0; m_gap = 1;
`ifdef ARB2_TIMEOUT_EN
            end else if (m_held == int'(HOLD)) begin
               m_owner = 0; m_gap = 1; m_tout = 1;
`endif
            end else begin
               m_held++;
            end
         end
      end
   endtask

   function automatic logic [3:0] model_out();
      return {m_owner == 1, m_owner == 2, (m_owner != 0) || m_gap, m_tout};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      reset = 1; reqA = 0; reqB = 0; doneA = 0; doneB = 0;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; reqA = 1; reqB = 1; doneA = 0; doneB = 0;
      tick();
      tick();
      checks++;
      if ({gntA, gntB, busy, tout} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0000", {gntA, gntB, busy, tout});
      end
      reqA = 0; reqB = 0; reset = 0;
      tick();
      checks++;
      if ({gntA, gntB, busy, tout} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle got %b want 0000", {gntA, gntB, busy, tout});
      end
   endtask

   task automatic test_single();
      logic [3:0] want [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b0000};
      reqA = 1;
      for (int i = 0; i < 6; i++) begin
         doneA = (i == 4);
         if (i == 5) reqA = 0;
         tick();
         checks++;
         if ({gntA, gntB, busy, tout} !== want[i]) begin
            errors++;
            $display("FAIL single_step%0d got %b want %b", i, {gntA, gntB, busy, tout}, want[i]);
         end
      end
      doneA = 0;
   endtask

   task automatic test_foreign_done();
      logic [3:0] want [6] = '{4'b1010, 4'b1010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      for (int i = 0; i < 6; i++) begin
         reqA  = (i < 2);
         doneB = (i == 1);
         doneA = (i == 4);
         tick();
         checks++;
         if ({gntA, gntB, busy, tout} !== want[i]) begin
            errors++;
            $display("FAIL foreign_step%0d got %b want %b", i, {gntA, gntB, busy, tout}, want[i]);
         end
      end
      doneA = 0; doneB = 0;
   endtask

   task automatic test_reset_mid_grant();
      logic [3:0] want [5] = '{4'b1010, 4'b0000, 4'b1010, 4'b0010, 4'b0000};
      for (int i = 0; i < 5; i++) begin
         reqA  = (i < 3);
         reset = (i == 1);
         tick();
         checks++;
         if ({gntA, gntB, busy, tout} !== want[i]) begin
            errors++;
            $display("FAIL rst_mid_step%0d got %b want %b", i, {gntA, gntB, busy, tout}, want[i]);
         end
      end
      reset = 0;
   endtask

   task automatic test_contention();
      bit seq [$];
      int gcnt = 0;
      int gapc = 0;
      bit prev_g = 0;
      do_reset();
      reqA = 1; reqB = 1;
      for (int i = 0; i < 60 && seq.size() < 4; i++) begin
         doneA = gntA && (gcnt == 2);
         doneB = gntB && (gcnt == 2);
         tick();
         checks++;
         if ({gntA, gntB, busy, tout} !== model_out() || (gntA && gntB)) begin
            errors++;
            $display("FAIL contention_cyc%0d got %b want %b", i, {gntA, gntB, busy, tout},
                     model_out());
         end
         if ((gntA || gntB) && !prev_g) begin
            if (seq.size() > 0) begin
               checks++;
               if (gapc !== 1) begin
                  errors++;
                  $display("FAIL contention_gap got %0d want 1", gapc);
               end
            end
            seq.push_back(gntB);
            gapc = 0;
         end
         if (!gntA && !gntB && busy) gapc++;
         gcnt   = (gntA || gntB) ? gcnt + 1 : 0;
         prev_g = gntA || gntB;
      end
      checks++;
      if (seq.size() != 4 || seq[0] || !seq[1] || seq[2] || !seq[3]) begin
         errors++;
         $display("FAIL contention_order got %0d grants want order A,B,A,B", seq.size());
      end
      reqA = 0; reqB = 0; doneA = 0; doneB = 0;
      tick(); tick(); tick();
   endtask

   task automatic test_timeout();
      int n = 0;
      do_reset();
      reqA = 1; reqB = 1;
      tick();
      for (int i = 0; i < 12 && gntA; i++) begin
         n++;
         tick();
      end
`ifdef ARB2_TIMEOUT_EN
      checks++;
      if (n != int'(HOLD) || {gntA, gntB, busy, tout} !== 4'b0011) begin
         errors++;
         $display("FAIL timeout_len got %0d cycles out %b want %0d cycles out 0011", n,
                  {gntA, gntB, busy, tout}, HOLD);
      end
      tick();
      checks++;
      if ({gntA, gntB, busy, tout} !== 4'b0000) begin
         errors++;
         $display("FAIL timeout_pulse got %b want 0000", {gntA, gntB, busy, tout});
      end
      tick();
      checks++;
      if ({gntA, gntB, busy, tout} !== 4'b0110) begin
         errors++;
         $display("FAIL timeout_next got %b want 0110", {gntA, gntB, busy, tout});
      end
`else
      checks++;
      if (n != 12 || gntA !== 1'b1 || tout !== 1'b0) begin
         errors++;
         $display("FAIL unbounded_hold got %0d cycles gntA %b want 12 cycles gntA 1", n, gntA);
      end
`endif
      reqA = 0; reqB = 0;
      tick(); tick(); tick();
   endtask

   task automatic test_done_timeout();
      do_reset();
      reqA = 1;
      tick();
      tick(); tick(); tick();
      checks++;
      if ({gntA, gntB, busy, tout} !== 4'b1010) begin
         errors++;
         $display("FAIL done_to_hold got %b want 1010", {gntA, gntB, busy, tout});
      end
      doneA = 1;
      tick();
      checks++;
      if ({gntA, gntB, busy, tout} !== 4'b0010) begin
         errors++;
         $display("FAIL done_to_release got %b want 0010", {gntA, gntB, busy, tout});
      end
      doneA = 0; reqA = 0;
      tick(); tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 5) == 0) reqA = ~reqA;
         if ($urandom_range(0, 5) == 0) reqB = ~reqB;
         doneA = ($urandom_range(0, 4) == 0);
         doneB = ($urandom_range(0, 4) == 0);
         tick();
         checks++;
         if ({gntA, gntB, busy, tout} !== model_out() || (gntA && gntB)) begin
            errors++;
            $display("FAIL random_cyc%0d got %b want %b", i, {gntA, gntB, busy, tout},
                     model_out());
         end
      end
      reset = 0; reqA = 0; reqB = 0; doneA = 0; doneB = 0;
   endtask

   initial begin
      reset = 1; reqA = 0; reqB = 0; doneA = 0; doneB = 0;
      test_reset();
      test_single();
      test_foreign_done();
      test_reset_mid_grant();
      test_contention();
      test_timeout();
      test_done_timeout();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
